// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty
// compare, shadow period/duty registers committed only at a period boundary.
// Optional build macro: PWM_CENTER_ALIGN_EN selects an up/down counter
// (centre-aligned PWM); without it the counter is edge-aligned only.
module pwm_multi_gen #(
  parameter int CH             = 4,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 999,
  parameter int DEFAULT_DUTY   = 500
) (
  input  logic                      clk_pwm,
  input  logic                      clr_pwm,
  input  logic                      en,
  input  logic                      wr_en,
  input  logic [$clog2(CH+1)-1:0]   wr_addr,
  input  logic [CNT_W-1:0]          wr_data,
  input  logic                      upd_req,
  output logic                      upd_busy,
  output logic                      period_end,
  output logic [CH-1:0]             PWM
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] duty_sh_q  [CH];
  logic [CNT_W-1:0] duty_sh_d  [CH];
  logic [CNT_W-1:0] duty_act_q [CH];
  logic [CNT_W-1:0] duty_act_d [CH];
  logic [CH-1:0]    pwm_q, pwm_d;
  logic             pend_q, pend_d;
  logic             period_end_q, period_end_d;
  logic             en_q, en_d;
  logic             commit;
  logic             run;
`ifdef PWM_CENTER_ALIGN_EN
  logic             dir_q, dir_d;   // 1 = counting down
`endif

  // Shadow register writes; addresses above CH fall through untouched.
  always_comb begin
    period_sh_d = period_sh_q;
    for (int i = 0; i < CH; i++) duty_sh_d[i] = duty_sh_q[i];
    if (wr_en) begin
      if (int'(wr_addr) == CH) period_sh_d = wr_data;
      for (int i = 0; i < CH; i++) begin
        if (int'(wr_addr) == i) duty_sh_d[i] = wr_data;
      end
    end
  end

  // Commit at a boundary cycle, or immediately while stopped. The commit
  // copies the registered shadows, so a write in the commit cycle waits.
  always_comb begin
    commit       = pend_q && (period_end_q || !en);
    pend_d       = upd_req || (pend_q && !commit);
    period_act_d = commit ? period_sh_q : period_act_q;
    for (int i = 0; i < CH; i++) duty_act_d[i] = commit ? duty_sh_q[i] : duty_act_q[i];
  end

  // Counter, compare and boundary flag. The first enabled edge only parks
  // the counter at 0, so a period always starts cleanly after en rises.
  always_comb begin
    en_d  = en;
    run   = en && en_q;
    cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d = 1'b0;
    if (run && !commit && (period_act_q != '0)) begin
      if (dir_q) begin
        cnt_d = cnt_q - CNT_W'(1);
        dir_d = (cnt_d != '0);
      end else if (cnt_q >= period_act_q) begin
        cnt_d = cnt_q - CNT_W'(1);
        dir_d = (cnt_d != '0);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (period_act_d == '0)
      period_end_d = en && (cnt_d == '0);
    else
      period_end_d = en && (cnt_d == CNT_W'(1)) && (dir_d || (period_act_d == CNT_W'(1)));
`else
    if (run && !commit) begin
      cnt_d = (cnt_q >= period_act_q) ? '0 : cnt_q + CNT_W'(1);
    end
    period_end_d = en && (cnt_d == period_act_d);
`endif
    for (int i = 0; i < CH; i++) pwm_d[i] = run && (cnt_q < duty_act_q[i]);
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk_pwm) begin
    if (clr_pwm) begin
      cnt_q        <= '0;
      pwm_q        <= '0;
      pend_q       <= 1'b0;
      period_end_q <= 1'b0;
      en_q         <= 1'b0;
      period_sh_q  <= CNT_W'(DEFAULT_PERIOD);
      period_act_q <= CNT_W'(DEFAULT_PERIOD);
      for (int i = 0; i < CH; i++) begin
        duty_sh_q[i]  <= CNT_W'(DEFAULT_DUTY);
        duty_act_q[i] <= CNT_W'(DEFAULT_DUTY);
      end
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      pend_q       <= pend_d;
      period_end_q <= period_end_d;
      en_q         <= en_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      for (int i = 0; i < CH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= dir_d;
`endif
    end
  end

  assign PWM        = pwm_q;
  assign period_end = period_end_q;
  assign upd_busy   = pend_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen (edge-aligned build, CH=4, CNT_W=16).
module tb_pwm_multi_gen;

  logic        clk = 1'b0;
  logic        clr_pwm, en, wr_en, upd_req;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        upd_busy, period_end;
  logic [3:0]  pwm;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] pwm;
    logic       pe;
  } vec_t;
  vec_t vt [10];

  pwm_multi_gen #(.CH(4), .CNT_W(16), .DEFAULT_PERIOD(999), .DEFAULT_DUTY(500)) dut (
    .clk_pwm(clk), .clr_pwm(clr_pwm), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .upd_req(upd_req), .upd_busy(upd_busy),
    .period_end(period_end), .PWM(pwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Advance until a boundary cycle; returns how many cycles that took.
  task automatic wait_pe(output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!period_end && waited < 2000);
    if (!period_end) chk("wait_pe_timeout", 0, 1);
  endtask

  initial begin
    int w, highs;
    logic exp1, expb;

    vt[0] = '{4'b1100, 1'b0};
    vt[1] = '{4'b1110, 1'b0};
    vt[2] = '{4'b1110, 1'b0};
    vt[3] = '{4'b1110, 1'b0};
    vt[4] = '{4'b1100, 1'b0};
    vt[5] = '{4'b1100, 1'b0};
    vt[6] = '{4'b1100, 1'b0};
    vt[7] = '{4'b1100, 1'b0};
    vt[8] = '{4'b1100, 1'b0};
    vt[9] = '{4'b1100, 1'b1};

    clr_pwm = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; upd_req = 1'b0;
    step(); step();
    chk("reset_pwm", pwm, 0);
    chk("reset_pe", period_end, 0);
    chk("reset_busy", upd_busy, 0);

    // Program period 9, duties 0/3/10/12 and commit while stopped.
    clr_pwm = 1'b0;
    wr(3'd4, 16'd9); wr(3'd0, 16'd0); wr(3'd1, 16'd3); wr(3'd2, 16'd10); wr(3'd3, 16'd12);
    upd_req = 1'b1; step(); upd_req = 1'b0;
    chk("busy_set", upd_busy, 1);
    step();
    chk("stopped_commit_busy", upd_busy, 0);
    chk("stopped_pwm_low", pwm, 0);

    en = 1'b1;
    step();
    chk("en_rise_cnt0_pwm", pwm, 0);
    step();
    chk("first_pwm_edge", pwm, 4'b1110);
    wait_pe(w);
    chk("first_period_end", w, 8);

    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("vec%0d_pwm", k), pwm, vt[k].pwm);
      chk($sformatf("vec%0d_pe", k), period_end, vt[k].pe);
    end

    // Mid-period duty change: old duty to the boundary, new one afterwards.
    for (int c = 0; c < 20; c++) begin
      int k;
      step();
      k = c % 10;
      exp1 = (c >= 10) ? (k >= 1 && k <= 7) : (k >= 1 && k <= 3);
      expb = (c < 10) && (k >= 5);
      chk($sformatf("mid_upd_pwm1_c%0d", c), pwm[1], exp1);
      chk($sformatf("mid_upd_busy_c%0d", c), upd_busy, expb);
      if (c == 4) begin
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'd7; upd_req = 1'b1;
      end else begin
        wr_en = 1'b0; upd_req = 1'b0;
      end
    end

    // Clear at cnt=6 with a commit pending.
    for (int c = 0; c <= 6; c++) begin
      step();
      if (c == 2) begin
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd4; upd_req = 1'b1;
      end else begin
        wr_en = 1'b0; upd_req = 1'b0;
      end
      if (c == 6) clr_pwm = 1'b1;
    end
    step();
    chk("clr_pwm_low", pwm, 0);
    chk("clr_pe_low", period_end, 0);
    chk("clr_busy_low", upd_busy, 0);
    clr_pwm = 1'b0;
    wait_pe(w);
    chk("default_period_len", w, 1000);
    highs = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (pwm[1]) highs++;
    end
    chk("default_duty_high", highs, 500);
    chk("default_period_end", period_end, 1);

    // Reprogram while stopped; writes above CH must be ignored.
    en = 1'b0;
    wr(3'd4, 16'd9); wr(3'd1, 16'd3); wr(3'd5, 16'd1); wr(3'd6, 16'd1); wr(3'd7, 16'd1);
    upd_req = 1'b1; step(); upd_req = 1'b0;
    step();
    chk("reprog_busy", upd_busy, 0);
    en = 1'b1;
    step(); step();
    wait_pe(w);
    chk("reprog_period_end", w, 8);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("ignored_addr_pwm1_k%0d", k), pwm[1], (k >= 1 && k <= 3));
    end

    // Request pending at a boundary, plus a new request and period write there.
    for (int k = 0; k < 10; k++) begin
      step();
      wr_en = 1'b0; upd_req = 1'b0;
      if (k == 5) upd_req = 1'b1;
      if (k == 9) begin
        chk("pend_at_boundary", upd_busy, 1);
        upd_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'd4;
      end
    end
    step();
    wr_en = 1'b0; upd_req = 1'b0;
    chk("second_commit_pending", upd_busy, 1);
    wait_pe(w);
    chk("commit_old_shadow_len", w, 9);
    chk("busy_before_second", upd_busy, 1);
    wait_pe(w);
    chk("commit_new_period_len", w, 5);
    chk("busy_after_second", upd_busy, 0);
    wait_pe(w);
    chk("new_period_repeat", w, 5);

    // Zero period: counter parked, boundary every cycle.
    en = 1'b0;
    wr(3'd4, 16'd0);
    upd_req = 1'b1; step(); upd_req = 1'b0;
    step();
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("zero_period_pe%0d", k), period_end, 1);
    end
    chk("zero_period_pwm1", pwm[1], 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
